// File: rtl/muldiv_arbiter.sv
// Round-robin arbiter sharing one multiply/divide unit between NUM_REQ requesters.
// Holds op/sign stable while busy, routes the result to the owner, and drains flushed ops.
module muldiv_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_src0,
  input  logic [NUM_REQ*DATA_W-1:0] req_src1,
  input  logic [NUM_REQ*2-1:0]      req_op,
  input  logic [NUM_REQ-1:0]        req_sign,
  input  logic [NUM_REQ-1:0]        flush,
  output logic [NUM_REQ-1:0]        resp_valid,
  input  logic [NUM_REQ-1:0]        resp_ready,
  output logic [DATA_W-1:0]         resp_res0,
  output logic [DATA_W-1:0]         resp_res1,
  output logic                      mdu_in_valid,
  input  logic                      mdu_in_ready,
  output logic [DATA_W-1:0]         mdu_src0,
  output logic [DATA_W-1:0]         mdu_src1,
  output logic [1:0]                mdu_op,
  output logic                      mdu_sign,
  input  logic                      mdu_out_valid,
  output logic                      mdu_out_ready,
  input  logic [DATA_W-1:0]         mdu_res0,
  input  logic [DATA_W-1:0]         mdu_res1,
  output logic                      busy,
  output logic [OW-1:0]             owner
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]         state;
  logic [OW-1:0]      rr_ptr;
  logic [OW-1:0]      owner_q;
  logic [OW-1:0]      grant;
  logic               killed;
  logic [1:0]         op_q;
  logic               sign_q;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] above_ptr;
  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] pick;
  logic               discard;

  assign eligible = req_valid & ~flush;
  assign discard  = killed | flush[owner_q];

  // Requesters at or above the pointer win; otherwise wrap to the lowest eligible index.
  always_comb begin
    above_ptr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      above_ptr[i] = (i >= int'(rr_ptr));
    end
    masked = eligible & above_ptr;
    pick   = (|masked) ? masked : eligible;
    grant  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pick[i]) grant = OW'(i);
    end
  end

  always_comb begin
    req_ready     = '0;
    resp_valid    = '0;
    mdu_in_valid  = 1'b0;
    mdu_src0      = '0;
    mdu_src1      = '0;
    mdu_op        = 2'd0;
    mdu_sign      = 1'b0;
    mdu_out_ready = 1'b0;
    if (!reset) begin
      if (state == S_IDLE) begin
        if (|eligible) begin
          mdu_in_valid     = 1'b1;
          req_ready[grant] = mdu_in_ready;
          mdu_src0         = req_src0[int'(grant)*DATA_W +: DATA_W];
          mdu_src1         = req_src1[int'(grant)*DATA_W +: DATA_W];
          mdu_op           = req_op[int'(grant)*2 +: 2];
          mdu_sign         = req_sign[grant];
        end
      end else begin
        // The unit steers its result mux from in_op, so op/sign stay driven while busy.
        mdu_op   = op_q;
        mdu_sign = sign_q;
        resp_valid[owner_q] = mdu_out_valid & ~discard;
        mdu_out_ready       = discard | resp_ready[owner_q];
      end
    end
  end

  assign resp_res0 = mdu_res0;
  assign resp_res1 = mdu_res1;
  assign busy      = (state == S_BUSY);
  assign owner     = owner_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      owner_q <= '0;
      killed  <= 1'b0;
      op_q    <= 2'd0;
      sign_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mdu_in_valid && mdu_in_ready) begin
            state   <= S_BUSY;
            owner_q <= grant;
            op_q    <= req_op[int'(grant)*2 +: 2];
            sign_q  <= req_sign[grant];
            rr_ptr  <= (grant == OW'(NUM_REQ - 1)) ? '0 : grant + OW'(1);
            killed  <= 1'b0;
          end
        end
        default: begin
          // Completion takes priority over a same-cycle flush; discard already covers it.
          if (mdu_out_valid && mdu_out_ready) begin
            state  <= S_IDLE;
            killed <= 1'b0;
          end else if (flush[owner_q]) begin
            killed <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_arbiter.md
Name: muldiv_arbiter

Overview:
Round-robin arbiter sharing one multiply/divide unit between NUM_REQ requesters (e.g. two issue pipes or a core plus a coprocessor port). Grants one request at a time and holds the unit's operand/op lines stable while the operation is in flight. Routes the result back to the owning requester only. Lets a requester flush its outstanding operation; the arbiter drains and discards the result.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_W, 32, operand/result width; matches the unit (32)

Ports:
clock  input  1  system clock
reset  input  1  reset, synchronous, active-high
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester request accepted
req_src0  input  NUM_REQ*DATA_W  operand 0, requester i at bits [i*DATA_W +: DATA_W]
req_src1  input  NUM_REQ*DATA_W  operand 1, same packing
req_op  input  NUM_REQ*2  op per requester (1 = mul, 2 = div; forwarded verbatim)
req_sign  input  NUM_REQ  signed-operation flag per requester
flush  input  NUM_REQ  kill request/outstanding op of requester i
resp_valid  output  NUM_REQ  result valid, one-hot at most
resp_ready  input  NUM_REQ  requester accepts result
resp_res0  output  DATA_W  result low / quotient (shared bus)
resp_res1  output  DATA_W  result high / remainder (shared bus)
mdu_in_valid  output  1  to unit in_valid
mdu_in_ready  input  1  from unit in_ready
mdu_src0  output  DATA_W  to unit in_src0
mdu_src1  output  DATA_W  to unit in_src1
mdu_op  output  2  to unit in_op
mdu_sign  output  1  to unit in_sign
mdu_out_valid  input  1  from unit out_valid
mdu_out_ready  output  1  to unit out_ready
mdu_res0  input  DATA_W  from unit out_res0
mdu_res1  input  DATA_W  from unit out_res1
busy  output  1  operation outstanding
owner  output  clog2(NUM_REQ)  requester index of outstanding op

Behaviour:
- Reset state: IDLE, rr_ptr=0, owner=0, killed=0, op_q=0. Outputs: req_ready=0, resp_valid=0, mdu_in_valid=0, mdu_out_ready=0, busy=0, mdu_op=0.
- States: IDLE, BUSY.
- IDLE: eligible = req_valid & ~flush. Grant g = first eligible index at or after rr_ptr, wrapping modulo NUM_REQ. mdu_in_valid = |eligible. mdu_src0/src1/op/sign = requester g fields, combinational. req_ready[g] = mdu_in_ready; all other req_ready bits = 0. With nothing eligible, mdu_op=0 and mdu_src*=0.
- Issue handshake (mdu_in_valid & mdu_in_ready): go to BUSY. owner<=g, op_q<=req_op[g], sign_q<=req_sign[g], rr_ptr<=(g+1) mod NUM_REQ, killed<=0.
- BUSY: mdu_in_valid=0, all req_ready=0. mdu_op=op_q and mdu_sign=sign_q, held stable because the unit selects its result mux from in_op. mdu_src*=0. busy=1.
- BUSY with flush[owner]=1: killed<=1, sticky until return to IDLE.
- Response: discard = killed | flush[owner]. resp_valid[owner] = mdu_out_valid & ~discard. mdu_out_ready = discard ? 1 : resp_ready[owner]. resp_res0/res1 = mdu_res0/res1, passed straight through.
- Completion (mdu_out_valid & mdu_out_ready): next state IDLE, killed<=0. The next issue occurs no earlier than the following cycle, so minimum spacing is 1 idle cycle between ops.
- Flush in the completion cycle wins: the result is discarded, and resp_valid stays low that cycle.
- Flush of a non-owner has no effect in BUSY. In IDLE it masks that requester from the grant that cycle.
- Requesters must hold the req_* fields stable while req_valid=1 and req_ready=0. The arbiter does not check this.
- Reset mid-operation: the arbiter returns to IDLE immediately. The unit shares the same reset, so no stale response is expected. Any response still arriving is not routed, because mdu_out_ready=0 in IDLE.
- No combinational path from resp_ready to req_ready.

Test Plan:
- Single request: req0 op=1 sign=0, src0=7, src1=6 -> issued; resp_valid[0]=1 with res0=42, res1=0; busy drops the cycle after the response handshake.
- Contention: req0 and req1 valid continuously, both div (100/7) -> grants alternate 0,1,0,1; each gets res0=14, res1=2; resp_valid never asserted for the non-owner.
- Op hold: owner issues div and its req_op changes to 1 while BUSY -> mdu_op stays 2 until completion; the result is the div result.
- Flush in flight: req1 issues mul, flush[1] pulsed 2 cycles later -> resp_valid[1] stays 0, mdu_out_ready=1 when the unit completes, arbiter returns to IDLE and grants the waiting req0 next.
- Backpressure: resp_ready[0]=0 for 5 cycles after result -> resp_valid[0] held high with a stable value, mdu_out_ready=0, no new issue; releasing resp_ready completes the op.
- Reset during BUSY: assert reset for 1 cycle mid-div -> busy=0, all req_ready=0, rr_ptr=0; next request from req0 is granted first.
